// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM states and Booth digit encoding for the multiplier family
package mult_pkg;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   typedef struct packed {
      logic neg;
      logic two;
      logic zero;
   } booth_t;

endpackage

// File: rtl/booth4_enc.sv
// booth4_enc: radix-4 Booth recoding of a 3-bit multiplier window into {neg,two,zero}
module booth4_enc
   import mult_pkg::*;
(
   input  logic [2:0] q_i,
   output booth_t     dig_o
);

   // 000/111 -> 0, 001/010 -> +X, 011 -> +2X, 100 -> -2X, 101/110 -> -X
   always_comb begin
      dig_o.neg  = q_i[2] & ~(q_i[1] & q_i[0]);
      dig_o.two  = (q_i == 3'b011) | (q_i == 3'b100);
      dig_o.zero = (q_i == 3'b000) | (q_i == 3'b111);
   end

endmodule

// File: rtl/mult_booth4_seq.sv
// mult_booth4_seq: iterative radix-4 Booth multiplier with start/ready/done handshake
module mult_booth4_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = 66
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   output logic                 ready,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result
);

   // two extra bits make unsigned operands positive in a signed datapath
   localparam int W2   = WIDTH + 2;
   localparam int ITER = WIDTH / 2 + 1;
   localparam int CW   = $clog2(ITER + 1);

   state_t             state_q, state_d;
   logic [W2:0]        acc_q, acc_d, q_q, q_d, xp_q, xp_d, xn_q, xn_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] res_q, res_d;
   booth_t             dig;
   logic [W2:0]        xe, pp, sum;
   logic [2*W2+1:0]    sh;
   logic               sx, sy;

   booth4_enc u_enc (
      .q_i   (q_q[2:0]),
      .dig_o (dig)
   );

   // operand capture, one Booth step per RUN cycle, and the IDLE/RUN/DONE sequencing
   always_comb begin
      sx      = is_signed & x[WIDTH-1];
      sy      = is_signed & y[WIDTH-1];
      xe      = {{3{sx}}, x};
      pp      = dig.zero ? '0 :
                dig.neg  ? (dig.two ? {xn_q[W2-1:0], 1'b0} : xn_q) :
                           (dig.two ? {xp_q[W2-1:0], 1'b0} : xp_q);
      sum     = acc_q + pp;
      sh      = $signed({sum, q_q}) >>> 2;
      state_d = state_q;
      acc_d   = acc_q;
      q_d     = q_q;
      xp_d    = xp_q;
      xn_d    = xn_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      if (state_q == S_IDLE && start) begin
         state_d = S_RUN;
         xp_d    = xe;
         xn_d    = -xe;
         acc_d   = '0;
         q_d     = {{2{sy}}, y, 1'b0};
         cnt_d   = '0;
      end else if (state_q == S_RUN) begin
         acc_d = sh[2*W2+1:W2+1];
         q_d   = sh[W2:0];
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(ITER - 1)) begin
            state_d = S_DONE;
            res_d   = sh[2*WIDTH:1];
         end
      end else if (state_q == S_DONE) begin
         state_d = S_IDLE;
      end
   end

   // state register; reset clears the result and aborts any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         q_q     <= '0;
         xp_q    <= '0;
         xn_q    <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         xp_q    <= xp_d;
         xn_q    <= xn_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   assign ready  = (state_q == S_IDLE);
   assign done   = (state_q == S_DONE);
   assign result = res_q;

endmodule

// File: tb/tb_mult_booth4_seq.sv
// tb_mult_booth4_seq: scoreboard bench for 8-bit and 66-bit Booth multipliers
module tb_mult_booth4_seq;

   localparam int IT8  = 5;
   localparam int IT66 = 34;

   typedef struct {
      logic [131:0] exp;
      int           t;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          st8 = 1'b0, sg8 = 1'b0, rdy8, dn8;
   logic [7:0]    x8 = '0, y8 = '0;
   logic [15:0]   r8, last8 = '0;
   logic          st66 = 1'b0, sg66 = 1'b0, rdy66, dn66;
   logic [65:0]   x66 = '0, y66 = '0;
   logic [131:0]  r66, last66 = '0;
   logic          pd8 = 1'b0, pd66 = 1'b0;
   int            cyc = 0, n_chk = 0, n_fail = 0;
   exp_t          q8[$], q66[$];

   mult_booth4_seq #(.WIDTH(8)) d8 (
      .clk(clk), .rst(rst), .start(st8), .is_signed(sg8), .x(x8), .y(y8),
      .ready(rdy8), .done(dn8), .result(r8)
   );

   mult_booth4_seq #(.WIDTH(66)) d66 (
      .clk(clk), .rst(rst), .start(st66), .is_signed(sg66), .x(x66), .y(y66),
      .ready(rdy66), .done(dn66), .result(r66)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [131:0] act, input logic [131:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // sign/zero-extend to 132 bits, multiply, keep the low 2*w bits
   function automatic logic [131:0] ref_mul(input int w, input bit s, input logic [65:0] a, input logic [65:0] b);
      logic [131:0] ea = 132'(a);
      logic [131:0] eb = 132'(b);
      if (s && a[w-1]) ea = ea | ({132{1'b1}} << w);
      if (s && b[w-1]) eb = eb | ({132{1'b1}} << w);
      return (ea * eb) & ({132{1'b1}} >> (132 - 2 * w));
   endfunction

   function automatic logic [65:0] rnd66();
      return 66'({$urandom(), $urandom(), $urandom()});
   endfunction

   task automatic wait_rdy(input bit w);
      int n = 0;
      while (!(w ? rdy66 : rdy8) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("wait_ready", 132'(w ? rdy66 : rdy8), 132'(1));
   endtask

   // drive one start pulse, queue its expectation, then scramble the inputs
   task automatic issue(input bit w, input bit s, input logic [65:0] a, input logic [65:0] b, output int t);
      wait_rdy(w);
      t = cyc;
      if (w) begin
         st66 = 1'b1; sg66 = s; x66 = a; y66 = b;
         q66.push_back('{ref_mul(66, s, a, b), cyc});
      end else begin
         st8 = 1'b1; sg8 = s; x8 = a[7:0]; y8 = b[7:0];
         q8.push_back('{ref_mul(8, s, a, b), cyc});
      end
      @(negedge clk);
      st8  = 1'b0;
      st66 = 1'b0;
      sg8  = 1'($urandom());
      sg66 = 1'($urandom());
      x8   = 8'($urandom());
      y8   = 8'($urandom());
      x66  = rnd66();
      y66  = rnd66();
   endtask

   // scoreboard: every done pops one expectation and checks value, latency and pulse width
   always @(negedge clk) begin
      exp_t e;
      if (pd8 && !rst) check("hold8", 132'(r8), 132'(last8));
      if (pd66 && !rst) check("hold66", r66, last66);
      if (dn8) begin
         check("pulse8", 132'(pd8), 132'(0));
         if (q8.size() == 0) check("spur8", 132'(dn8), 132'(0));
         else begin
            e = q8.pop_front();
            check("res8", 132'(r8), e.exp);
            check("lat8", 132'(cyc - e.t), 132'(IT8 + 1));
         end
      end
      if (dn66) begin
         check("pulse66", 132'(pd66), 132'(0));
         if (q66.size() == 0) check("spur66", 132'(dn66), 132'(0));
         else begin
            e = q66.pop_front();
            check("res66", r66, e.exp);
            check("lat66", 132'(cyc - e.t), 132'(IT66 + 1));
         end
      end
      pd8    = dn8;
      pd66   = dn66;
      last8  = r8;
      last66 = r66;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 90000", cyc);
      $fatal(1);
   end

   initial begin
      int t, n;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_rdy8", 132'(rdy8), 132'(1));
      check("rst_done8", 132'(dn8), 132'(0));
      check("rst_res8", 132'(r8), 132'(0));
      check("rst_rdy66", 132'(rdy66), 132'(1));
      check("rst_done66", 132'(dn66), 132'(0));
      check("rst_res66", r66, 132'(0));
      issue(0, 1, 66'h80, 66'h80, t);
      issue(0, 0, 66'hFF, 66'hFF, t);
      issue(0, 1, 66'hFF, 66'hFF, t);
      issue(0, 1, 66'h7F, 66'h80, t);
      issue(0, 0, 66'h7F, 66'h80, t);
      issue(0, 0, 66'h00, 66'h5A, t);
      issue(0, 1, 66'h00, 66'h80, t);
      issue(0, 1, 66'h12, 66'hC4, t);
      @(negedge clk);
      st8 = 1'b1; sg8 = 1'b0; x8 = 8'hAA; y8 = 8'h55;
      check("busy_start8", 132'(rdy8), 132'(0));
      @(negedge clk);
      st8 = 1'b0;
      while (cyc < t + IT8 + 2) begin
         check("busy8", 132'(rdy8), 132'(0));
         @(negedge clk);
      end
      wait_rdy(0);
      for (int i = 0; i < 8; i++) begin
         st8 = 1'b1; sg8 = 1'b1; x8 = 8'hFD; y8 = 8'h05;
         if (i % 7 == 0) q8.push_back('{ref_mul(8, 1, 66'hFD, 66'h05), cyc});
         check("thru_rdy8", 132'(rdy8), 132'(i % 7 == 0));
         @(negedge clk);
      end
      st8 = 1'b0;
      issue(0, 1, 66'h55, 66'h66, t);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q8.delete();
      check("abort_rdy8", 132'(rdy8), 132'(1));
      check("abort_done8", 132'(dn8), 132'(0));
      check("abort_res8", 132'(r8), 132'(0));
      issue(0, 1, 66'hC3, 66'h3C, t);
      issue(1, 1, {66{1'b1}}, {66{1'b1}}, t);
      issue(1, 0, {66{1'b1}}, {66{1'b1}}, t);
      issue(1, 1, 66'(1) << 65, 66'(1) << 65, t);
      issue(1, 0, 66'(1) << 65, {66{1'b1}}, t);
      for (int i = 0; i < 1000; i++) issue(1, i[0], (i % 97 == 0) ? {66{1'b1}} : rnd66(), rnd66(), t);
      n = 0;
      while ((q8.size() + q66.size()) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", 132'(q8.size() + q66.size()), 132'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
